cl_serial_ctrl: RTL and testbench



---
 rtl/cl_serial_ctrl.sv | 99 +++++++++
 tb/tb_cl_serial_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cl_serial_ctrl.sv
// Bit-serial sequencer around a 1-bit logic cell: streams two latched operands
// LSB-first through the cell and assembles the WIDTH-bit result.
module cl_serial_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             cell_a,
    output logic             cell_b,
    output logic [1:0]       cell_s,
    input  logic             cell_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   r_sh_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   r_sh_d;

    // Result shifts in from the MSB so bit 0 ends up in position 0 after WIDTH steps.
    assign r_sh_d = {cell_out, r_sh_q[WIDTH-1:1]};

    // Cell drive is decoded from registers only; operand bits are gated outside RUN.
    assign cell_a = (state_q == RUN) ? a_sh_q[0] : 1'b0;
    assign cell_b = (state_q == RUN) ? b_sh_q[0] : 1'b0;
    assign cell_s = op_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in;
                        op_q    <= op;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    r_sh_q <= r_sh_d;
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Last bit captured this edge: publish the full word.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result  <= r_sh_d;
                        zero    <= (r_sh_d == '0);
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cl_serial_ctrl.sv
// Self-checking bench for cl_serial_ctrl with a behavioural logic cell attached.
module tb_cl_serial_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cell_a;
    logic         cell_b;
    logic [1:0]   cell_s;
    logic         cell_out;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // The 1-bit cell the sequencer drives.
    always_comb begin
        case (cell_s)
            2'b00:   cell_out = cell_a & cell_b;
            2'b01:   cell_out = cell_a | cell_b;
            2'b10:   cell_out = cell_a ^ cell_b;
            default: cell_out = ~cell_a;
        endcase
    end

    cl_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in),
        .cell_a(cell_a), .cell_b(cell_b), .cell_s(cell_s), .cell_out(cell_out),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One complete operation; inputs are scrambled after the start cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic z, output int lat,
                          output int busy_cyc, output logic drive_ok, output logic post_ok);
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        sa = a;
        sb = b;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom);
        lat = 1; busy_cyc = 0; drive_ok = 1'b1;
        while (lat < 20) begin
            if (busy) busy_cyc++;
            if (cell_s !== o) drive_ok = 1'b0;
            if (lat <= int'(W)) begin
                if (cell_a !== sa[0] || cell_b !== sb[0]) drive_ok = 1'b0;
                sa = sa >> 1;
                sb = sb >> 1;
            end else if (cell_a !== 1'b0 || cell_b !== 1'b0) begin
                drive_ok = 1'b0;
            end
            if (done) break;
            @(negedge clk);
            lat++;
        end
        res = result;
        z = zero;
        @(negedge clk);
        post_ok = (busy === 1'b0) && (done === 1'b0) && (result === res);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [W-1:0] res;
        logic         z;
        int           lat;
        int           bc;
        logic         dok;
        logic         pok;
        int           dones;
        int           last_done;
        logic         prev_done;
        logic         stable_ok;
        logic         gap_ok;
        logic         seen;

        vecs[0] = '{2'b00, 4'b1100, 4'b1010, 4'b1000, 1'b0};
        vecs[1] = '{2'b01, 4'b1100, 4'b1010, 4'b1110, 1'b0};
        vecs[2] = '{2'b10, 4'b0110, 4'b0110, 4'b0000, 1'b1};
        vecs[3] = '{2'b11, 4'b0101, 4'b1111, 4'b1010, 1'b0};
        vecs[4] = '{2'b10, 4'b1010, 4'b0011, 4'b1001, 1'b0};

        reset = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_result", 32'(result), 0);
        check("reset_cell_s", 32'(cell_s), 0);
        reset = 1'b0;

        // Directed vectors from the table.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, bc, dok, pok);
            check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp_zero));
            check($sformatf("vec%0d_latency", i), 32'(lat), W + 1);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), W + 1);
            check($sformatf("vec%0d_cell_drive", i), 32'(dok), 1);
            check($sformatf("vec%0d_post_done", i), 32'(pok), 1);
        end

        // Second start during RUN is dropped; a_in toggles mid-run.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a_in = 4'b0011; b_in = 4'b0101;
        @(negedge clk);
        op = 2'b01; a_in = 4'b1111; b_in = 4'b1111;
        @(negedge clk);
        a_in = 4'b0000;
        @(negedge clk);
        start = 1'b0; a_in = 4'b1010;
        dones = 0; res = '0;
        for (int c = 0; c < 15; c++) begin
            if (done) begin dones++; res = result; end
            @(negedge clk);
        end
        check("ignore_start_dones", 32'(dones), 1);
        check("ignore_start_result", 32'(res), 32'(4'b0001));
        check("ignore_start_idle", 32'(busy), 0);

        // Reset on the 2nd RUN cycle aborts the job.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a_in = 4'b1111; b_in = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_result", 32'(result), 0);
        check("abort_zero", 32'(zero), 0);
        check("abort_cell_ab", 32'({cell_a, cell_b}), 0);
        check("abort_cell_s", 32'(cell_s), 0);
        start = 1'b1;
        @(negedge clk);
        check("reset_beats_start", 32'(busy), 0);
        reset = 1'b0; start = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dones), 0);
        run_op(2'b10, 4'b1010, 4'b0011, res, z, lat, bc, dok, pok);
        check("after_abort_result", 32'(res), 32'(4'b1001));

        // Start held high: one completion every W+2 cycles.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a_in = 4'b0101; b_in = 4'b0011;
        dones = 0; last_done = -1; prev_done = 1'b0;
        stable_ok = 1'b1; gap_ok = 1'b1; seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                if (prev_done) gap_ok = 1'b0;
                if (last_done >= 0 && c - last_done != int'(W) + 2) gap_ok = 1'b0;
                last_done = c;
                dones++;
                seen = 1'b1;
            end
            if (seen && result !== model(2'b01, 4'b0101, 4'b0011)) stable_ok = 1'b0;
            prev_done = done;
        end
        start = 1'b0;
        check("b2b_done_count", 32'(dones), 6);
        check("b2b_spacing", 32'(gap_ok), 1);
        check("b2b_result_stable", 32'(stable_ok), 1);
        for (int c = 0; c < 12 && busy; c++) @(negedge clk);
        check("b2b_drained", 32'(busy), 0);

        // Random operations against the word-level model.
        for (int i = 0; i < 30; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [W-1:0] er;
            ro = 2'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            er = model(ro, ra, rb);
            run_op(ro, ra, rb, res, z, lat, bc, dok, pok);
            check($sformatf("rand%0d_result", i), 32'(res), 32'(er));
            check($sformatf("rand%0d_zero", i), 32'(z), 32'(er == '0));
            check($sformatf("rand%0d_timing", i), 32'({dok, pok}), 32'(2'b11));
            check($sformatf("rand%0d_latency", i), 32'(lat), W + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
